vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port 16 KB video RAM between the CRTC display fetch and ISA CPU accesses.
- Each character period is split into fixed slots:
  - two video fetch slots (character byte and attribute byte, or two graphics bytes);
  - one guaranteed CPU slot;
  - an extra CPU slot in place of the video slots during blanking.
- CPU accesses never corrupt the display fetch ("snow-free").
- The CPU side sees a busy/done handshake that the ISA glue turns into IOCHRDY wait states.

Parameters:
- SLOT_CYCLES, 8, clk cycles per character period (divclk period). Must be at least CPU_PHASE+3.
- CPU_PHASE, 4, phase index of the guaranteed CPU slot. Must be at least 3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- divclk  in  1  character-clock enable, one-cycle pulse per character period
- disp_en  in  1  CRTC display enable
- gfx_mode  in  1  0 = text addressing, 1 = CGA graphics addressing
- crtc_addr  in  14  CRTC memory address
- crtc_row  in  5  CRTC row address
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_busy  out  1  request captured, not yet completed
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid from cpu_done onward
- ram_addr  out  14  VRAM byte address
- ram_we  out  1  VRAM write strobe
- ram_wdata  out  8  VRAM write data
- ram_rdata  in  8  VRAM read data, valid the cycle after the address
- vid_byte0  out  8  fetched character / first graphics byte
- vid_byte1  out  8  fetched attribute / second graphics byte
- vid_valid  out  1  one-cycle pulse: vid_byte0/1 updated

Behaviour:
- Reset values: all outputs 0; phase = SLOT_CYCLES-1; no pending request. Reset mid-access drops the access and cpu_done is not pulsed.
- Phase counter:
  - divclk=1 sets phase to 0 on the next cycle.
  - Otherwise phase increments and saturates at SLOT_CYCLES-1.
  - An early divclk restarts the period. With no divclk, no new slots are issued.
- Sampling on the divclk cycle: crtc_addr, crtc_row[0], gfx_mode and disp_en are registered. Call the registered disp_en blank_n.
- Video addresses:
  - Text mode: A0 = {crtc_addr[12:0],0}, A1 = {crtc_addr[12:0],1}.
  - Graphics mode: A0 = {crtc_row[0],crtc_addr[11:0],0}, A1 = A0|1.
  - All arithmetic is 14-bit and wraps.
- Video fetch when blank_n=1:
  - Phase 0 drives A0; phase 1 drives A1, with ram_we=0.
  - The edge ending phase 1 loads vid_byte0 from ram_rdata.
  - The edge ending phase 2 loads vid_byte1, and vid_valid is high during phase 3.
- Video fetch when blank_n=0: no fetch, vid_bytes hold, no vid_valid pulse, and phase 0 becomes a CPU slot.
- CPU capture:
  - In any cycle with cpu_busy=0 and cpu_req=1, addr/we/wdata are latched and cpu_busy=1 from the next cycle.
  - cpu_req while busy is ignored; the requester holds or re-asserts after done.
- CPU slot: at the first CPU slot (phase CPU_PHASE, or phase 0 when blanking) with cpu_busy=1 at that cycle's start:
  - ram_addr and ram_wdata come from the latch, and ram_we = latched we for that cycle.
  - A request captured in the same cycle as a slot waits for the next slot.
- CPU completion:
  - The cycle after the slot, cpu_rdata captures ram_rdata (reads only; writes leave cpu_rdata unchanged).
  - The following cycle has cpu_done=1 and cpu_busy=0.
  - A new cpu_req in the done cycle is accepted.
- Idle cycles: ram_addr=0, ram_we=0, ram_wdata holds.
- Worst-case CPU latency, request to done: 2*SLOT_CYCLES+2 cycles.

Decomposition:
- Shared package vram_pkg:
  - VRAM address width 14;
  - default SLOT_CYCLES and CPU_PHASE;
  - phase slot constants PH_VID0=0 and PH_VID1=1.
- One natural sub-module, vram_slot_timer: the phase counter plus the slot-decode strobes vid0_slot, vid1_slot, cpu_slot. It is reusable by the MDA variant.
- The address mux, CPU latch and capture registers stay in vram_arbiter.

Test Plan:
- Text fetch: divclk with crtc_addr=0x0123, disp_en=1, gfx_mode=0, VRAM[0x0246]=0x41, VRAM[0x0247]=0x1F -> ram_addr 0x0246 then 0x0247, vid_byte0=0x41, vid_byte1=0x1F, vid_valid in phase 3.
- Graphics fetch: gfx_mode=1, crtc_row=1, crtc_addr=0x0010 -> ram_addr 0x2020 then 0x2021.
- CPU write during display: write 0x5A to 0x1000 at phase 1 -> ram_we high only at phase 4, cpu_done at phase 6, later read of 0x1000 returns 0x5A. vid_valid timing is unaffected.
- Blanking fast path: disp_en=0, read of 0x0002 requested before divclk -> access at phase 0, cpu_done at phase 2, no vid_valid, and a second queued request is served at phase 4.
- Back-to-back and ignored requests: cpu_req held continuously across done -> new access starts in the next slot. Changing cpu_addr while busy -> the first address is used.
- Reset mid-access: reset_n low at the slot cycle -> all outputs 0, no cpu_done. After release, the first divclk restarts phase 0 correctly.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants and types for the video RAM arbiter and its slot timer.
package vram_pkg;
  localparam int VRAM_AW         = 14;
  localparam int SLOT_CYCLES_DEF = 8;
  localparam int CPU_PHASE_DEF   = 4;
  localparam int PH_VID0         = 0;
  localparam int PH_VID1         = 1;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_PEND = 2'd1,
    C_RESP = 2'd2
  } cpu_st_e;

  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         wdata;
  } cpu_req_t;
endpackage

// File: rtl/vram_slot_timer.sv
// Character-period phase counter and slot decode shared by the CGA/MDA arbiters.
module vram_slot_timer
  import vram_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int CPU_PHASE   = CPU_PHASE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic divclk,
  input  logic blank_n,
  output logic vid0_slot,
  output logic vid1_slot,
  output logic cpu_slot
);
  localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);

  logic [PW-1:0] phase;

  // Saturating at the last phase means a missing divclk stops issuing slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             phase <= PH_LAST;
    else if (divclk)          phase <= '0;
    else if (phase != PH_LAST) phase <= phase + PW'(1);
  end

  assign vid0_slot = blank_n && (phase == PW'(PH_VID0));
  assign vid1_slot = blank_n && (phase == PW'(PH_VID1));
  assign cpu_slot  = (phase == PW'(CPU_PHASE)) || (!blank_n && (phase == PW'(PH_VID0)));
endmodule

// File: rtl/vram_arbiter.sv
// Snow-free sharing of one single-port VRAM between CRTC fetch and ISA CPU accesses.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int CPU_PHASE   = CPU_PHASE_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                divclk,
  input  logic                disp_en,
  input  logic                gfx_mode,
  input  logic [VRAM_AW-1:0]  crtc_addr,
  input  logic [4:0]          crtc_row,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [VRAM_AW-1:0]  cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic                cpu_busy,
  output logic                cpu_done,
  output logic [7:0]          cpu_rdata,
  output logic [VRAM_AW-1:0]  ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic [7:0]          vid_byte0,
  output logic [7:0]          vid_byte1,
  output logic                vid_valid
);
  localparam int STAGES = 2;

  logic [12:0]       addr_q;
  logic              row0_q, gfx_q, blank_n;
  logic              vid0_slot, vid1_slot, cpu_slot;
  logic [STAGES:0]   vld_pipe;
  logic [VRAM_AW-1:0] a0;
  cpu_st_e           st_q, st_d;
  cpu_req_t          lat;
  logic [7:0]        wdata_hold;
  logic              serve;

  logic unused_ok;
  assign unused_ok = ^{crtc_addr[13], crtc_row[4:1]};

  vram_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES), .CPU_PHASE(CPU_PHASE)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .divclk    (divclk),
    .blank_n   (blank_n),
    .vid0_slot (vid0_slot),
    .vid1_slot (vid1_slot),
    .cpu_slot  (cpu_slot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      row0_q  <= 1'b0;
      gfx_q   <= 1'b0;
      blank_n <= 1'b0;
    end else if (divclk) begin
      addr_q  <= crtc_addr[12:0];
      row0_q  <= crtc_row[0];
      gfx_q   <= gfx_mode;
      blank_n <= disp_en;
    end
  end

  assign a0 = gfx_q ? {row0_q, addr_q[11:0], 1'b0} : {addr_q, 1'b0};
  assign cpu_busy = (st_q != C_IDLE);

  // CPU slot and video slots are mutually exclusive by construction of the timer.
  always_comb begin
    serve     = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = wdata_hold;
    if (st_q == C_PEND && cpu_slot) begin
      serve     = 1'b1;
      ram_addr  = lat.addr;
      ram_we    = lat.we;
      ram_wdata = lat.wdata;
    end else if (vid0_slot) begin
      ram_addr  = a0;
    end else if (vid1_slot) begin
      ram_addr  = a0 | VRAM_AW'(1);
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      C_IDLE:  if (cpu_req) st_d = C_PEND;
      C_PEND:  if (serve)   st_d = C_RESP;
      C_RESP:  st_d = C_IDLE;
      default: st_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= C_IDLE;
      lat        <= '0;
      wdata_hold <= '0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      st_q     <= st_d;
      cpu_done <= (st_q == C_RESP);
      if (st_q == C_IDLE && cpu_req) lat <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      if (serve) wdata_hold <= lat.wdata;
      if (st_q == C_RESP && !lat.we) cpu_rdata <= ram_rdata;
    end
  end

  // vld_pipe[0] is high in phase 1 (byte0 data on ram_rdata), [1] in phase 2, [2] in phase 3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      vid_byte0 <= '0;
      vid_byte1 <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], vid0_slot};
      if (vld_pipe[0]) vid_byte0 <= ram_rdata;
      if (vld_pipe[1]) vid_byte1 <= ram_rdata;
    end
  end

  assign vid_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port VRAM.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        divclk, disp_en, gfx_mode;
  logic [13:0] crtc_addr;
  logic [4:0]  crtc_row;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy, cpu_done;
  logic [7:0]  cpu_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  vid_byte0, vid_byte1;
  logic        vid_valid;

  logic        tb_we;
  logic [13:0] tb_waddr;
  logic [7:0]  tb_wdata;
  logic [7:0]  mem [0:16383];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .divclk(divclk), .disp_en(disp_en),
    .gfx_mode(gfx_mode), .crtc_addr(crtc_addr), .crtc_row(crtc_row),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .vid_byte0(vid_byte0), .vid_byte1(vid_byte1), .vid_valid(vid_valid)
  );

  // Synchronous-read RAM: data for an address appears the following cycle.
  always @(posedge clk) begin
    if (tb_we)       mem[tb_waddr] <= tb_wdata;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in phase 0 of a new character period.
  task automatic divpulse();
    divclk = 1'b1;
    step();
    divclk = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(cpu_busy),  0);
    chk({tag, "_done"},  32'(cpu_done),  0);
    chk({tag, "_rdata"}, 32'(cpu_rdata), 0);
    chk({tag, "_raddr"}, 32'(ram_addr),  0);
    chk({tag, "_rwe"},   32'(ram_we),    0);
    chk({tag, "_rwd"},   32'(ram_wdata), 0);
    chk({tag, "_vb0"},   32'(vid_byte0), 0);
    chk({tag, "_vb1"},   32'(vid_byte1), 0);
    chk({tag, "_vv"},    32'(vid_valid), 0);
  endtask

  initial begin
    logic [13:0] pre_a [5];
    logic [7:0]  pre_d [5];
    pre_a = '{14'h0246, 14'h0247, 14'h2020, 14'h2021, 14'h0002};
    pre_d = '{8'h41, 8'h1F, 8'hAA, 8'h55, 8'hC3};

    reset_n = 1'b0; divclk = 1'b0; disp_en = 1'b0; gfx_mode = 1'b0;
    crtc_addr = '0; crtc_row = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

    for (int i = 0; i < 5; i++) begin
      tb_we = 1'b1; tb_waddr = pre_a[i]; tb_wdata = pre_d[i];
      step();
    end
    tb_we = 1'b0;
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step(2);
    chk("idle_raddr", 32'(ram_addr), 0);

    // Text fetch
    crtc_addr = 14'h0123; disp_en = 1'b1; gfx_mode = 1'b0;
    divpulse();
    chk("txt_a0", 32'(ram_addr), 32'h0246);
    chk("txt_we0", 32'(ram_we), 0);
    step();
    chk("txt_a1", 32'(ram_addr), 32'h0247);
    step();
    chk("txt_vb0", 32'(vid_byte0), 32'h41);
    chk("txt_vv_ph2", 32'(vid_valid), 0);
    step();
    chk("txt_vb1", 32'(vid_byte1), 32'h1F);
    chk("txt_vv_ph3", 32'(vid_valid), 1);
    step();
    chk("txt_vv_ph4", 32'(vid_valid), 0);
    step(3);

    // Graphics fetch
    gfx_mode = 1'b1; crtc_row = 5'd1; crtc_addr = 14'h0010;
    divpulse();
    chk("gfx_a0", 32'(ram_addr), 32'h2020);
    step();
    chk("gfx_a1", 32'(ram_addr), 32'h2021);
    step();
    chk("gfx_vb0", 32'(vid_byte0), 32'hAA);
    step();
    chk("gfx_vb1", 32'(vid_byte1), 32'h55);
    chk("gfx_vv", 32'(vid_valid), 1);
    step(4);

    // CPU write during display
    gfx_mode = 1'b0; crtc_row = 5'd0; crtc_addr = 14'h0123;
    divpulse();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1000; cpu_wdata = 8'h5A;
    step();
    cpu_req = 1'b0;
    chk("wr_busy_ph2", 32'(cpu_busy), 1);
    chk("wr_we_ph2", 32'(ram_we), 0);
    step();
    chk("wr_we_ph3", 32'(ram_we), 0);
    chk("wr_vv_ph3", 32'(vid_valid), 1);
    step();
    chk("wr_we_ph4", 32'(ram_we), 1);
    chk("wr_addr_ph4", 32'(ram_addr), 32'h1000);
    chk("wr_wd_ph4", 32'(ram_wdata), 32'h5A);
    step();
    chk("wr_we_ph5", 32'(ram_we), 0);
    chk("wr_done_ph5", 32'(cpu_done), 0);
    chk("wr_busy_ph5", 32'(cpu_busy), 1);
    step();
    chk("wr_done_ph6", 32'(cpu_done), 1);
    chk("wr_busy_ph6", 32'(cpu_busy), 0);
    chk("wr_rdata_hold", 32'(cpu_rdata), 0);
    step();
    chk("wr_done_ph7", 32'(cpu_done), 0);
    chk("wr_wd_hold", 32'(ram_wdata), 32'h5A);

    // Read back 0x1000, captured on the divclk cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1000;
    divpulse();
    cpu_req = 1'b0;
    chk("rd_busy_ph0", 32'(cpu_busy), 1);
    step(6);
    chk("rd_done", 32'(cpu_done), 1);
    chk("rd_data", 32'(cpu_rdata), 32'h5A);
    step();

    // Blanking fast path and queued second request
    disp_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0002;
    divpulse();
    cpu_req = 1'b0;
    chk("blk_addr_ph0", 32'(ram_addr), 32'h0002);
    chk("blk_we_ph0", 32'(ram_we), 0);
    step();
    chk("blk_done_ph1", 32'(cpu_done), 0);
    step();
    chk("blk_done_ph2", 32'(cpu_done), 1);
    chk("blk_rdata", 32'(cpu_rdata), 32'hC3);
    cpu_req = 1'b1; cpu_addr = 14'h0246;
    step();
    cpu_req = 1'b0;
    chk("blk_busy2", 32'(cpu_busy), 1);
    chk("blk_vv_ph3", 32'(vid_valid), 0);
    step();
    chk("blk_addr_ph4", 32'(ram_addr), 32'h0246);
    step(2);
    chk("blk_done2", 32'(cpu_done), 1);
    chk("blk_rdata2", 32'(cpu_rdata), 32'h41);
    chk("blk_vb0_hold", 32'(vid_byte0), 32'h41);
    chk("blk_vb1_hold", 32'(vid_byte1), 32'h1F);
    step();

    // Back-to-back with held request; address change while busy is ignored
    disp_en = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h11;
    divpulse();
    cpu_addr = 14'h0200; cpu_wdata = 8'h22;
    chk("b2b_vid_ph0", 32'(ram_addr), 32'h0246);
    step(4);
    chk("b2b_addr1", 32'(ram_addr), 32'h0100);
    chk("b2b_wd1", 32'(ram_wdata), 32'h11);
    step(2);
    chk("b2b_done1", 32'(cpu_done), 1);
    step();
    cpu_req = 1'b0;
    chk("b2b_busy2", 32'(cpu_busy), 1);
    divpulse();
    step(4);
    chk("b2b_addr2", 32'(ram_addr), 32'h0200);
    chk("b2b_wd2", 32'(ram_wdata), 32'h22);
    chk("b2b_we2", 32'(ram_we), 1);
    step(2);
    chk("b2b_done2", 32'(cpu_done), 1);
    step();

    // Reset in the middle of an access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0002;
    divpulse();
    cpu_req = 1'b0;
    step(4);
    chk("rst_slot_addr", 32'(ram_addr), 32'h0002);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step(2);
    chk("rst_no_done", 32'(cpu_done), 0);
    reset_n = 1'b1;
    step(3);
    chk("rst_post_done", 32'(cpu_done), 0);
    chk("rst_post_busy", 32'(cpu_busy), 0);
    chk("rst_post_addr", 32'(ram_addr), 0);
    crtc_addr = 14'h0123; gfx_mode = 1'b0; disp_en = 1'b1;
    divpulse();
    chk("rst_re_a0", 32'(ram_addr), 32'h0246);
    step(3);
    chk("rst_re_vv", 32'(vid_valid), 1);
    chk("rst_re_vb1", 32'(vid_byte1), 32'h1F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
